fingertip_tracker: RTL and testbench
====================================

FINGERTIP_TRACKER -- requirements
Module: fingertip_tracker

Interface
REQ-001 Parameter H_RES, 320: pixels per line.
REQ-002 Parameter V_RES, 240: lines per frame; frame holds H_RES*V_RES = 76800 pixels.
REQ-003 Parameter R_MIN, 5'd20: minimum R5 for a marker pixel.
REQ-004 Parameter G_MAX, 6'd24: maximum G6 for a marker pixel.
REQ-005 Parameter B_MAX, 5'd12: maximum B5 for a marker pixel.
REQ-006 Parameter RUN_MIN, 4: consecutive marker pixels in one line that form a fingertip candidate.
REQ-007 Parameter MIN_COUNT, 64: minimum marker pixels per frame for a valid tip.
REQ-008 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-009 iCLK  in  1: pixel clock, the capture-side PCLK domain.
REQ-010 iRST_N  in  1: asynchronous active-low reset.
REQ-011 pix_we  in  1: pixel-valid strobe from the capture stage.
REQ-012 pix_addr  in  17: linear pixel address, 0..76799, raster order.
REQ-013 pix_data  in  16: RGB565 pixel, R=[15:11], G=[10:5], B=[4:0].
REQ-014 mask_we  out  1: registered copy of pix_we.
REQ-015 mask_addr  out  17: registered copy of pix_addr.
REQ-016 mask_bit  out  1: 1 when the pixel met the colour test.
REQ-017 tip_x  out  9: fingertip column.
REQ-018 tip_y  out  8: fingertip row.
REQ-019 tip_valid  out  1: the published tip is trustworthy.
REQ-020 tip_strobe  out  1: one-cycle pulse when the tip outputs update.

Function
REQ-021 Colour test: the pixel is a marker when R > R_MIN, G < G_MAX and B < B_MAX; all comparisons are unsigned.
REQ-022 Mask path: mask_we, mask_addr and mask_bit follow their inputs with exactly 1 cycle of latency; mask_bit is 0 whenever pix_we=0.
REQ-023 FSM states: SYNC, SEARCH, LOCKED; reset enters SYNC.
REQ-024 SYNC: ignore pixels until pix_we=1 with pix_addr=0, then clear x, y, run, count and go to SEARCH with that pixel processed.
REQ-025 Pixel tracking: an internal expected address advances by 1 per accepted pixel; x counts 0..H_RES-1, wraps to 0 and increments y; no divider is used.
REQ-026 Run counter: increments on a marker pixel, clears on a non-marker pixel and at every line wrap, and saturates at RUN_MIN.
REQ-027 SEARCH->LOCKED: on the first pixel where run reaches RUN_MIN, latch cand_x = x-(RUN_MIN-1)+RUN_MIN/2 and cand_y = y; the first qualifying run in raster order wins.
REQ-028 LOCKED: no further candidate updates; marker counting continues.
REQ-029 Marker count: 17-bit counter of marker pixels per frame; it cannot overflow.
REQ-030 Frame end: on an accepted pixel with pix_addr=H_RES*V_RES-1, on the next cycle tip_strobe=1, tip_x/tip_y take cand_x/cand_y, and tip_valid = (state was LOCKED) AND (count incl. this pixel >= MIN_COUNT); FSM then enters SEARCH, expecting address 0.
REQ-031 When no run qualified, tip_x/tip_y keep their previous values, tip_valid=0 and tip_strobe still pulses.
REQ-032 Address discontinuity: when pix_addr differs from the expected address and is nonzero, abort the frame, emit no strobe, and go to SYNC.
REQ-033 pix_addr=0 mid-frame: restart the frame immediately (as in REQ-024), emit no strobe.
REQ-034 pix_we=0 cycles: hold all counters; gaps of any length are legal.
REQ-035 Published outputs: tip_x, tip_y and tip_valid change only together with tip_strobe.

Reset
REQ-036 On iRST_N=0, all outputs and counters clear to 0 and the FSM enters SYNC, asynchronously; release is synchronous to iCLK.
REQ-037 Reset mid-frame discards the partial frame; the first strobe after reset requires a full frame starting at address 0.

Structure
REQ-038 Package video_pkg holds H_RES, V_RES, the frame size constant, the RGB565 field offsets and the FSM state enum.
REQ-039 Sub-module rgb565_marker_cmp is combinational, with pix_data and thresholds as inputs and the marker bit as output; all sequential logic stays in fingertip_tracker.

Verification
REQ-040 Stimulus: full frame of 0x0000. Required: strobe 1 cycle after addr 76799; tip_valid=0; tip_x=0, tip_y=0.
REQ-041 Stimulus: frame with an 8x10 block of 0xF800 at x=100..107, y=50..59. Required: tip_x=102, tip_y=50, tip_valid=1 (80>=64).
REQ-042 Stimulus: 3-pixel 0xF800 runs on every line except a 4-pixel run at x=318..319 / next-line x=0..1. Required: no lock; tip_valid=0 (the run clears at line wrap).
REQ-043 Stimulus: addresses jump from 1000 to 1005 mid-frame. Required: no strobe for that frame; the next full frame strobes normally.
REQ-044 Stimulus: iRST_N pulsed low at addr 40000. Required: outputs are 0 immediately; no strobe until the following complete frame.
REQ-045 Stimulus: random pix_we gaps across the REQ-041 frame. Required: identical result to REQ-041; mask_bit matches the colour test with 1-cycle latency.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video geometry, RGB565 field layout and tracker FSM encoding.
package video_pkg;

  localparam int unsigned H_RES     = 320;
  localparam int unsigned V_RES     = 240;
  localparam int unsigned FRAME_PIX = H_RES * V_RES;
  localparam int unsigned ADDR_W    = 17;

  localparam int unsigned R_LSB = 11;
  localparam int unsigned R_W   = 5;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_LSB = 0;
  localparam int unsigned B_W   = 5;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } trk_state_t;

endpackage

// File: rtl/rgb565_marker_cmp.sv
// Combinational colour-threshold test on one RGB565 pixel.
module rgb565_marker_cmp
  import video_pkg::*;
(
  input  logic [15:0]    i_pix_data,
  input  logic [R_W-1:0] i_r_min,
  input  logic [G_W-1:0] i_g_max,
  input  logic [B_W-1:0] i_b_max,
  output logic           o_marker
);

  logic [R_W-1:0] w_r;
  logic [G_W-1:0] w_g;
  logic [B_W-1:0] w_b;

  assign w_r = i_pix_data[R_LSB +: R_W];
  assign w_g = i_pix_data[G_LSB +: G_W];
  assign w_b = i_pix_data[B_LSB +: B_W];

  assign o_marker = (w_r > i_r_min) && (w_g < i_g_max) && (w_b < i_b_max);

endmodule

// File: rtl/fingertip_tracker.sv
// Marker-colour mask generator and per-frame fingertip locator; publishes
// the first qualifying horizontal run of each complete frame.
module fingertip_tracker #(
  parameter int unsigned H_RES     = 320,
  parameter int unsigned V_RES     = 240,
  parameter logic [4:0]  R_MIN     = 5'd20,
  parameter logic [5:0]  G_MAX     = 6'd24,
  parameter logic [4:0]  B_MAX     = 5'd12,
  parameter int unsigned RUN_MIN   = 4,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        pix_we,
  input  logic [16:0] pix_addr,
  input  logic [15:0] pix_data,
  output logic        mask_we,
  output logic [16:0] mask_addr,
  output logic        mask_bit,
  output logic [8:0]  tip_x,
  output logic [7:0]  tip_y,
  output logic        tip_valid,
  output logic        tip_strobe
);
  import video_pkg::*;

  localparam int unsigned FRAME_LEN = H_RES * V_RES;
  localparam logic [16:0] LAST_ADDR = 17'(FRAME_LEN - 1);
  localparam logic [8:0]  X_LAST    = 9'(H_RES - 1);
  localparam int unsigned RUN_W     = $clog2(RUN_MIN + 1);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(RUN_MIN);
  // Run ends at x; centre = x - (RUN_MIN-1) + RUN_MIN/2, folded into one offset.
  localparam logic [8:0]  CAND_OFS  = 9'(RUN_MIN / 2) - 9'(RUN_MIN - 1);
  localparam logic [16:0] MIN_CNT   = 17'(MIN_COUNT);

  trk_state_t       r_state;
  logic [16:0]      r_exp_addr;
  logic [8:0]       r_x;
  logic [7:0]       r_y;
  logic [RUN_W-1:0] r_run;
  logic [16:0]      r_count;
  logic [8:0]       r_cand_x;
  logic [7:0]       r_cand_y;

  logic             w_marker;
  logic             w_first;
  logic             w_accept;
  logic             w_abort;
  logic [8:0]       w_x;
  logic [7:0]       w_y;
  logic [RUN_W-1:0] w_run_base;
  logic [RUN_W-1:0] w_run_inc;
  logic [16:0]      w_count_base;
  logic [16:0]      w_count_nxt;
  logic             w_search;
  logic             w_lock;
  logic             w_locked;
  logic [8:0]       w_cand_x;
  logic [7:0]       w_cand_y;
  logic             w_frame_end;

  rgb565_marker_cmp u_cmp (
    .i_pix_data (pix_data),
    .i_r_min    (R_MIN),
    .i_g_max    (G_MAX),
    .i_b_max    (B_MAX),
    .o_marker   (w_marker)
  );

  // Address 0 always (re)starts a frame, so it is processed as if all
  // per-frame counters were already cleared.
  always_comb begin
    w_first      = (pix_addr == '0);
    w_accept     = pix_we && (w_first ||
                   ((r_state != ST_SYNC) && (pix_addr == r_exp_addr)));
    w_abort      = pix_we && !w_accept && (r_state != ST_SYNC);
    w_x          = w_first ? '0 : r_x;
    w_y          = w_first ? '0 : r_y;
    w_run_base   = w_first ? '0 : r_run;
    w_count_base = w_first ? '0 : r_count;
    w_run_inc    = '0;
    if (w_marker) begin
      w_run_inc = (w_run_base == RUN_SAT) ? RUN_SAT : w_run_base + RUN_W'(1);
    end
    w_count_nxt  = w_count_base + 17'(w_marker);
    w_search     = w_first || (r_state == ST_SEARCH);
    w_lock       = w_accept && w_search && (w_run_inc == RUN_SAT);
    w_locked     = w_lock || (!w_first && (r_state == ST_LOCKED));
    w_cand_x     = w_lock ? (w_x + CAND_OFS) : r_cand_x;
    w_cand_y     = w_lock ? w_y : r_cand_y;
    w_frame_end  = w_accept && (pix_addr == LAST_ADDR);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= ST_SYNC;
      r_exp_addr <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_run      <= '0;
      r_count    <= '0;
      r_cand_x   <= '0;
      r_cand_y   <= '0;
      mask_we    <= 1'b0;
      mask_addr  <= '0;
      mask_bit   <= 1'b0;
      tip_x      <= '0;
      tip_y      <= '0;
      tip_valid  <= 1'b0;
      tip_strobe <= 1'b0;
    end else begin
      mask_we    <= pix_we;
      mask_addr  <= pix_addr;
      mask_bit   <= pix_we & w_marker;
      tip_strobe <= 1'b0;

      if (w_abort) begin
        r_state <= ST_SYNC;
      end else if (w_accept) begin
        r_cand_x <= w_cand_x;
        r_cand_y <= w_cand_y;
        if (w_frame_end) begin
          tip_strobe <= 1'b1;
          tip_valid  <= w_locked && (w_count_nxt >= MIN_CNT);
          if (w_locked) begin
            tip_x <= w_cand_x;
            tip_y <= w_cand_y;
          end
          r_state    <= ST_SEARCH;
          r_exp_addr <= '0;
          r_x        <= '0;
          r_y        <= '0;
          r_run      <= '0;
          r_count    <= '0;
        end else begin
          r_state    <= w_locked ? ST_LOCKED : ST_SEARCH;
          r_exp_addr <= pix_addr + 17'd1;
          r_count    <= w_count_nxt;
          if (w_x == X_LAST) begin
            r_x   <= '0;
            r_y   <= w_y + 8'd1;
            r_run <= '0;
          end else begin
            r_x   <= w_x + 9'd1;
            r_y   <= w_y;
            r_run <= w_run_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fingertip_tracker.sv
// Scoreboard bench for fingertip_tracker on a 320x16 frame (short frames keep
// the run brief; line length and all thresholds are the production values).
module tb_fingertip_tracker;

  localparam int H = 320;
  localparam int V = 16;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_we = 1'b0;
  logic [16:0] pix_addr = '0;
  logic [15:0] pix_data = '0;
  logic        mask_we;
  logic [16:0] mask_addr;
  logic        mask_bit;
  logic [8:0]  tip_x;
  logic [7:0]  tip_y;
  logic        tip_valid;
  logic        tip_strobe;

  fingertip_tracker #(.H_RES(H), .V_RES(V)) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .pix_we     (pix_we),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .mask_we    (mask_we),
    .mask_addr  (mask_addr),
    .mask_bit   (mask_bit),
    .tip_x      (tip_x),
    .tip_y      (tip_y),
    .tip_valid  (tip_valid),
    .tip_strobe (tip_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic        mbit;
    logic        strobe;
  } mask_exp_t;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic       v;
  } tip_exp_t;

  mask_exp_t mq[$];
  tip_exp_t  tq[$];
  int tests = 0;
  int fails = 0;
  logic [17:0] prev_tip = '0;

  function automatic logic model_marker(input logic [15:0] d);
    return (d[15:11] > 5'd20) && (d[10:5] < 6'd24) && (d[4:0] < 5'd12);
  endfunction

  // 0: black; 1: 8x10 red block at (100..107, 5..14) with threshold near-misses;
  // 2: 3-pixel runs plus a 4-run split across the line 3/4 wrap;
  // 3: 5x13 block (65 px); 4: 7x9 block (63 px).
  function automatic logic [15:0] pix(input int pat, input int x, input int y);
    case (pat)
      1: begin
        if (x >= 100 && x <= 107) begin
          if (y >= 5 && y <= 14) return 16'hF800;
          if (y == 2) return 16'hA000;
          if (y == 3) return 16'hFB00;
          if (y == 4) return 16'hF80C;
        end
        if (y == 0 && x <= 2) return 16'hAAEB;
        return 16'h001F;
      end
      2: begin
        if ((x >= 10 && x <= 12) || (y == 3 && x >= 318) || (y == 4 && x <= 1))
          return 16'hF800;
        return 16'h0000;
      end
      3: return (x >= 200 && x <= 204 && y >= 1 && y <= 13) ? 16'hF800 : 16'h0000;
      4: return (x >= 200 && x <= 206 && y >= 1 && y <= 9) ? 16'hF800 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic drive(input logic we, input logic [16:0] a, input logic [15:0] d,
                       input logic se);
    mask_exp_t e;
    @(negedge clk);
    pix_we   = we;
    pix_addr = a;
    pix_data = d;
    e.we = we; e.addr = a; e.mbit = we & model_marker(d); e.strobe = se;
    mq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, pix_addr, 16'hF800, 1'b0);
  endtask

  task automatic run_frame(input int pat, input int first, input int last,
                           input bit gaps, input bit strobe,
                           input logic [8:0] ex, input logic [7:0] ey, input logic ev);
    tip_exp_t t;
    if (strobe) begin
      t.x = ex; t.y = ey; t.v = ev;
      tq.push_back(t);
    end
    for (int a = first; a <= last; a++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      drive(1'b1, 17'(a), pix(pat, a % H, a / H), strobe && (a == N - 1));
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({mask_we, mask_addr, mask_bit, tip_x, tip_y, tip_valid, tip_strobe} !== '0) begin
      fails++;
      $display("FAIL %s: outputs we=%b addr=%0d bit=%b x=%0d y=%0d v=%b s=%b, required all 0",
               name, mask_we, mask_addr, mask_bit, tip_x, tip_y, tip_valid, tip_strobe);
    end
  endtask

  initial begin : monitor
    mask_exp_t m;
    tip_exp_t  t;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_tip = {tip_x, tip_y, tip_valid};
        continue;
      end
      if (mq.size() > 0) begin
        m = mq.pop_front();
        tests++;
        if ({mask_we, mask_addr, mask_bit} !== {m.we, m.addr, m.mbit}) begin
          fails++;
          $display("FAIL mask: got we=%b addr=%0d bit=%b, required we=%b addr=%0d bit=%b",
                   mask_we, mask_addr, mask_bit, m.we, m.addr, m.mbit);
        end
        tests++;
        if (tip_strobe !== m.strobe) begin
          fails++;
          $display("FAIL strobe at addr %0d: got %b, required %b", m.addr, tip_strobe, m.strobe);
        end else if (m.strobe) begin
          tests++;
          if (tq.size() == 0) begin
            fails++;
            $display("FAIL tip: strobe with no expected result queued");
          end else begin
            t = tq.pop_front();
            if ({tip_x, tip_y, tip_valid} !== {t.x, t.y, t.v}) begin
              fails++;
              $display("FAIL tip: got x=%0d y=%0d v=%b, required x=%0d y=%0d v=%b",
                       tip_x, tip_y, tip_valid, t.x, t.y, t.v);
            end
          end
        end
      end else begin
        tests++;
        if (tip_strobe !== 1'b0) begin
          fails++;
          $display("FAIL idle_strobe: got %b, required 0", tip_strobe);
        end
      end
      if (!tip_strobe) begin
        tests++;
        if ({tip_x, tip_y, tip_valid} !== prev_tip) begin
          fails++;
          $display("FAIL tip_hold: got %h, required %h", {tip_x, tip_y, tip_valid}, prev_tip);
        end
      end
      prev_tip = {tip_x, tip_y, tip_valid};
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    run_frame(0, 0, N - 1, 1'b0, 1'b1, 9'd0, 8'd0, 1'b0);
    run_frame(1, 0, N - 1, 1'b0, 1'b1, 9'd102, 8'd5, 1'b1);
    run_frame(2, 0, N - 1, 1'b0, 1'b1, 9'd102, 8'd5, 1'b0);

    // address jump aborts the frame; the rest of it must be ignored
    run_frame(3, 0, 1000, 1'b0, 1'b0, '0, '0, 1'b0);
    run_frame(3, 1005, N - 1, 1'b0, 1'b0, '0, '0, 1'b0);
    run_frame(3, 0, N - 1, 1'b0, 1'b1, 9'd202, 8'd1, 1'b1);
    run_frame(4, 0, N - 1, 1'b0, 1'b1, 9'd202, 8'd1, 1'b0);

    run_frame(1, 0, N - 1, 1'b1, 1'b1, 9'd102, 8'd5, 1'b1);

    // restart at address 0 mid-frame discards the earlier lock
    run_frame(3, 0, 3000, 1'b0, 1'b0, '0, '0, 1'b0);
    run_frame(0, 0, N - 1, 1'b0, 1'b1, 9'd102, 8'd5, 1'b0);

    run_frame(1, 0, 2499, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    pix_we = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(1, 2500, N - 1, 1'b0, 1'b0, '0, '0, 1'b0);
    run_frame(3, 0, N - 1, 1'b0, 1'b1, 9'd202, 8'd1, 1'b1);

    idle(4);
    for (int i = 0; i < 20 && mq.size() > 0; i++) @(posedge clk);
    #2;
    tests++;
    if (mq.size() != 0 || tq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d mask and %0d tip results outstanding, required 0",
               mq.size(), tq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
